// File: rtl/cpu_io_responder.sv
// cpu_io_responder
// Device-side endpoint of the CPU byte I/O port. The input FIFO is preloaded
// by the host and drained by the CPU through I/IEnable. The output FIFO is
// filled by the CPU through O/OEnable and drained by the host through
// out_data/out_pop.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_data, in_push  host byte to enqueue for the CPU
//   in_full, in_count input FIFO status
//   I, IEnable        byte presented to the CPU; CPU read strobe
//   O, OEnable        byte from the CPU; CPU write strobe
//   out_data          head of the output FIFO (0 when empty)
//   out_valid         output FIFO non-empty
//   out_pop           host consumes out_data
//   in_underrun       sticky: CPU read an empty input FIFO
//   out_overflow      sticky: CPU wrote a full output FIFO with no pop
//
// Configuration:
//   CPU_IO_RESP_ERR_FLAGS_EN  when defined, builds the sticky error flags;
//                             otherwise both flag outputs are tied to 0.
module cpu_io_responder #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_push,
    output logic                       in_full,
    output logic [$clog2(DEPTH):0]     in_count,
    output logic [WIDTH-1:0]           I,
    input  logic                       IEnable,
    input  logic [WIDTH-1:0]           O,
    input  logic                       OEnable,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_pop,
    output logic                       in_underrun,
    output logic                       out_overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    // ------------------------------------------------------------------
    // Input FIFO (host -> CPU)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] in_mem [DEPTH];
    logic [AW-1:0]    in_wr_ptr;
    logic [AW-1:0]    in_rd_ptr;
    logic [CW-1:0]    in_cnt;
    logic             in_empty;
    logic             in_wr_en;
    logic             in_rd_en;

    assign in_empty = (in_cnt == '0);
    assign in_full  = (in_cnt == CW'(DEPTH));
    assign in_count = in_cnt;

    // A full FIFO still accepts a push when the CPU frees a slot in the same cycle.
    assign in_wr_en = in_push && (!in_full || IEnable);
    assign in_rd_en = IEnable && !in_empty;

    // Head is never bypassed from in_data; empty reads return 0.
    assign I = in_empty ? '0 : in_mem[in_rd_ptr];

    always_ff @(posedge clk) begin
        if (in_wr_en) begin
            in_mem[in_wr_ptr] <= in_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_cnt    <= '0;
        end else begin
            if (in_wr_en) in_wr_ptr <= in_wr_ptr + AW'(1);
            if (in_rd_en) in_rd_ptr <= in_rd_ptr + AW'(1);
            if (in_wr_en && !in_rd_en)      in_cnt <= in_cnt + CW'(1);
            else if (!in_wr_en && in_rd_en) in_cnt <= in_cnt - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO (CPU -> host)
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_mem [DEPTH];
    logic [AW-1:0]    out_wr_ptr;
    logic [AW-1:0]    out_rd_ptr;
    logic [CW-1:0]    out_cnt;
    logic             out_empty;
    logic             out_full;
    logic             out_wr_en;
    logic             out_rd_en;

    assign out_empty = (out_cnt == '0);
    assign out_full  = (out_cnt == CW'(DEPTH));
    assign out_valid = !out_empty;

    // A full FIFO still captures when the host pops in the same cycle.
    assign out_wr_en = OEnable && (!out_full || out_pop);
    assign out_rd_en = out_pop && !out_empty;

    assign out_data = out_empty ? '0 : out_mem[out_rd_ptr];

    always_ff @(posedge clk) begin
        if (out_wr_en) begin
            out_mem[out_wr_ptr] <= O;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_cnt    <= '0;
        end else begin
            if (out_wr_en) out_wr_ptr <= out_wr_ptr + AW'(1);
            if (out_rd_en) out_rd_ptr <= out_rd_ptr + AW'(1);
            if (out_wr_en && !out_rd_en)      out_cnt <= out_cnt + CW'(1);
            else if (!out_wr_en && out_rd_en) out_cnt <= out_cnt - CW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags
    // ------------------------------------------------------------------
`ifdef CPU_IO_RESP_ERR_FLAGS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_underrun  <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            if (IEnable && in_empty)              in_underrun  <= 1'b1;
            if (OEnable && out_full && !out_pop)  out_overflow <= 1'b1;
        end
    end
`else
    assign in_underrun  = 1'b0;
    assign out_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_io_responder.sv
// Directed bench for cpu_io_responder with scoreboard queues per direction.
module tb_cpu_io_responder;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 8;
`ifdef CPU_IO_RESP_ERR_FLAGS_EN
    localparam logic FLAGS_EN = 1'b1;
`else
    localparam logic FLAGS_EN = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst;
    logic [WIDTH-1:0]       in_data;
    logic                   in_push;
    logic                   in_full;
    logic [$clog2(DEPTH):0] in_count;
    logic [WIDTH-1:0]       I;
    logic                   IEnable;
    logic [WIDTH-1:0]       O;
    logic                   OEnable;
    logic [WIDTH-1:0]       out_data;
    logic                   out_valid;
    logic                   out_pop;
    logic                   in_underrun;
    logic                   out_overflow;

    int tests_run = 0;
    int tests_failed = 0;

    logic [WIDTH-1:0] in_q[$];
    logic [WIDTH-1:0] out_q[$];
    logic [WIDTH-1:0] exp_b;

    cpu_io_responder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_push      (in_push),
        .in_full      (in_full),
        .in_count     (in_count),
        .I            (I),
        .IEnable      (IEnable),
        .O            (O),
        .OEnable      (OEnable),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_pop      (out_pop),
        .in_underrun  (in_underrun),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_push(input logic [WIDTH-1:0] v);
        in_data = v;
        in_push = 1'b1;
        if (in_q.size() < DEPTH) in_q.push_back(v);
        tick();
        in_push = 1'b0;
    endtask

    task automatic cpu_read(input string tag);
        exp_b = (in_q.size() != 0) ? in_q.pop_front() : '0;
        check(tag, 32'(I), 32'(exp_b));
        IEnable = 1'b1;
        tick();
        IEnable = 1'b0;
    endtask

    task automatic cpu_write(input logic [WIDTH-1:0] v);
        O = v;
        OEnable = 1'b1;
        if (out_q.size() < DEPTH) out_q.push_back(v);
        tick();
        OEnable = 1'b0;
    endtask

    task automatic host_pop(input string tag);
        exp_b = (out_q.size() != 0) ? out_q.pop_front() : '0;
        check(tag, 32'(out_data), 32'(exp_b));
        out_pop = 1'b1;
        tick();
        out_pop = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_data = '0; in_push = 1'b0; IEnable = 1'b0;
        O = '0; OEnable = 1'b0; out_pop = 1'b0;

        // Reset state
        tick();
        check("rst_in_full",      32'(in_full), 0);
        check("rst_in_count",     32'(in_count), 0);
        check("rst_I",            32'(I), 0);
        check("rst_out_data",     32'(out_data), 0);
        check("rst_out_valid",    32'(out_valid), 0);
        check("rst_in_underrun",  32'(in_underrun), 0);
        check("rst_out_overflow", 32'(out_overflow), 0);
        rst = 1'b0;
        tick();

        // Push three bytes, CPU reads them back in order
        host_push(8'h0F);
        check("push_latency_I", 32'(I), 32'h0F);
        host_push(8'h33);
        host_push(8'h7E);
        check("in_count_3", 32'(in_count), 3);
        for (int k = 0; k < 3; k++) begin
            check("in_count_step", 32'(in_count), 32'(3 - k));
            cpu_read("read_seq");
        end
        check("I_after_drain", 32'(I), 0);
        check("in_count_0", 32'(in_count), 0);

        // Underrun on empty read
        check("underrun_before", 32'(in_underrun), 0);
        cpu_read("empty_read_I");
        check("underrun_count", 32'(in_count), 0);
        check("underrun_I", 32'(I), 0);
        check("underrun_flag", 32'(in_underrun), 32'(FLAGS_EN));

        // Output FIFO overflow: 9 writes into DEPTH 8
        cpu_write(8'h01);
        check("out_valid_latency", 32'(out_valid), 1);
        check("out_data_latency", 32'(out_data), 32'h01);
        for (int k = 2; k <= 8; k++) cpu_write(8'(k));
        check("overflow_before", 32'(out_overflow), 0);
        cpu_write(8'h09);
        check("overflow_flag", 32'(out_overflow), 32'(FLAGS_EN));
        for (int k = 0; k < 8; k++) begin
            check("out_valid_drain", 32'(out_valid), 1);
            host_pop("out_drain");
        end
        check("out_valid_empty", 32'(out_valid), 0);
        check("out_data_empty", 32'(out_data), 0);
        out_pop = 1'b1;
        tick();
        out_pop = 1'b0;
        check("pop_empty_ignored", 32'(out_valid), 0);

        // Full input FIFO: drop on push, then push with simultaneous read
        for (int k = 0; k < 8; k++) host_push(8'(8'h10 + k));
        check("in_full", 32'(in_full), 1);
        check("in_count_8", 32'(in_count), 8);
        host_push(8'h99);
        check("full_drop_count", 32'(in_count), 8);
        exp_b = in_q.pop_front();
        check("full_rw_old_head", 32'(I), 32'(exp_b));
        in_q.push_back(8'hAA);
        in_data = 8'hAA; in_push = 1'b1; IEnable = 1'b1;
        tick();
        in_push = 1'b0; IEnable = 1'b0;
        check("full_rw_count", 32'(in_count), 8);
        for (int k = 0; k < 8; k++) cpu_read("full_rw_drain");
        check("full_rw_empty", 32'(in_count), 0);

        // Async reset with 4 entries in each FIFO
        for (int k = 0; k < 4; k++) begin
            host_push(8'(8'hC0 + k));
            cpu_write(8'(8'hD0 + k));
        end
        check("pre_rst_in_count", 32'(in_count), 4);
        check("pre_rst_out_valid", 32'(out_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_in_count",     32'(in_count), 0);
        check("arst_in_full",      32'(in_full), 0);
        check("arst_I",            32'(I), 0);
        check("arst_out_data",     32'(out_data), 0);
        check("arst_out_valid",    32'(out_valid), 0);
        check("arst_in_underrun",  32'(in_underrun), 0);
        check("arst_out_overflow", 32'(out_overflow), 0);
        #1;
        rst = 1'b0;
        in_q.delete();
        out_q.delete();
        tick();
        host_push(8'h5A);
        check("post_rst_I", 32'(I), 32'h5A);
        check("post_rst_count", 32'(in_count), 1);
        cpu_read("post_rst_read");

        // Simultaneous write/pop across pointer wrap
        for (int k = 0; k < 20; k++) begin
            O = 8'(8'h40 + k);
            OEnable = 1'b1;
            out_pop = (out_q.size() != 0);
            if (out_pop) begin
                exp_b = out_q.pop_front();
                check("stream_data", 32'(out_data), 32'(exp_b));
            end
            out_q.push_back(O);
            tick();
        end
        OEnable = 1'b0;
        out_pop = 1'b0;
        check("stream_overflow", 32'(out_overflow), 0);
        check("stream_last_valid", 32'(out_valid), 1);
        host_pop("stream_last");
        check("stream_empty", 32'(out_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cpu_io_responder.md
# cpu_io_responder

Device-side endpoint of the CPU's byte I/O port. It supplies bytes on `I` when the CPU strobes `IEnable` and captures bytes from `O` when the CPU strobes `OEnable`. Each direction has its own FIFO, so a host or bench can preload input bytes and drain output bytes independently of CPU timing. The block sits between the CPU I/O pins and the board/bench stimulus logic.

## Interface
Parameters:
- `DEPTH`, default 8: entries per FIFO; must be a power of 2, minimum 2.
- `WIDTH`, default 8: byte width; must match the CPU `I`/`O` width.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high; clears both FIFOs and both flags.
- `in_data` in WIDTH: host byte to enqueue for the CPU.
- `in_push` in 1: enqueue `in_data` this cycle.
- `in_full` out 1: input FIFO is full.
- `in_count` out $clog2(DEPTH)+1: input FIFO occupancy.
- `I` out WIDTH: byte presented to the CPU.
- `IEnable` in 1: CPU read strobe; consumes the head of the input FIFO.
- `O` in WIDTH: byte from the CPU.
- `OEnable` in 1: CPU write strobe; captures `O`.
- `out_data` out WIDTH: head of the output FIFO.
- `out_valid` out 1: output FIFO is non-empty.
- `out_pop` in 1: host consumes `out_data`.
- `in_underrun` out 1: sticky flag; the CPU read while the input FIFO was empty.
- `out_overflow` out 1: sticky flag; the CPU wrote while the output FIFO was full.

## Operation
- Each FIFO is a register array with read pointer, write pointer, and count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is one bit wider.
- `I` is combinational from the input FIFO head: `I` = head when `in_count` ≠ 0, otherwise 0.
- `out_data` is combinational from the output FIFO head; it is 0 when empty.
- Input FIFO:
  - `in_push` with `in_full` = 0: write and increment the write pointer.
  - `in_push` with `in_full` = 1 and no `IEnable`: drop the byte; no flag is raised.
  - `IEnable` with count ≠ 0: advance the read pointer.
  - `IEnable` with count = 0: `I` = 0, no pointer change, `in_underrun` is set.
  - Push and `IEnable` in the same cycle when full: both occur and the count is unchanged.
  - Push and `IEnable` in the same cycle when empty: the push is accepted, the CPU reads 0, and `in_underrun` is set. The pushed byte is not bypassed to `I`.
- Output FIFO:
  - `OEnable` with space available: capture `O`.
  - `OEnable` when full and no `out_pop`: drop the byte and set `out_overflow`.
  - `OEnable` and `out_pop` in the same cycle when full: both occur.
  - `out_pop` when empty: ignored.
  - `OEnable` and `out_pop` in the same cycle when empty: the capture is accepted and the pop is ignored.
- Sticky flags clear only on `rst`.

## Timing
- Reset values of all outputs are 0: `in_full`, `in_count`, `I`, `out_data`, `out_valid`, `in_underrun`, `out_overflow`. Memory contents are don't-care.
- Latency:
  - A pushed byte appears on `I` the cycle after the `in_push` edge.
  - After an `IEnable` edge, the next byte appears on `I` in the following cycle.
  - A captured `O` appears on `out_data` with `out_valid` = 1 one cycle after the `OEnable` edge.
- Throughput: one pop per cycle per FIFO, back-to-back.
- Flags assert on the clock edge of the offending strobe and are visible in the next cycle.
- `rst` asserted mid-operation empties both FIFOs immediately (asynchronous); in-flight strobes in that cycle are lost.
- `IEnable` and `OEnable` are single-cycle strobes from the CPU. A strobe held for N cycles counts as N accesses.

## Configuration
- `CPU_IO_RESP_ERR_FLAGS_EN`:
  - Defined: `in_underrun` and `out_overflow` are implemented as specified.
  - Not defined: both outputs are tied to 0 and their registers are not built. FIFO behaviour is otherwise identical, including dropping bytes on a full FIFO and returning 0 on an empty read.

## Test plan
- Reset, then push 0x0F, 0x33, 0x7E; pulse `IEnable` three times, one per cycle → `I` reads 0x0F, 0x33, 0x7E in sequence, then 0x00; `in_count` steps 3→0.
- Pulse `IEnable` on an empty FIFO → `I` = 0x00, `in_count` stays 0, `in_underrun` = 1 (0 when the macro is undefined).
- Issue 9 `OEnable` writes of 0x01..0x09 with DEPTH = 8 and no pops → `out_overflow` = 1; popping yields 0x01..0x08 and then `out_valid` = 0.
- Fill the input FIFO to 8, then `in_push` 0xAA together with `IEnable` → `I` shows the old head, `in_count` stays 8, and 0xAA is read last.
- Write and pop through the output FIFO for 20 bytes with simultaneous `OEnable`/`out_pop` → data order is preserved across pointer wrap and `out_overflow` stays 0.
- Assert `rst` asynchronously while both FIFOs hold 4 entries → all outputs are 0 immediately, and the next push shows up on `I` one cycle later.
